// File: rtl/block_interleaver_pp.sv
// rtl/block_interleaver_pp.sv - ping-pong ROWSxCOLS row-in/column-out block interleaver
// Optional feature macro: INTLV_FRAME_CNT_EN adds the frame_cnt output (completed output blocks).
module block_interleaver_pp #(
    parameter int DATA_W = 8,
    parameter int ROWS   = 3,
    parameter int COLS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof
`ifdef INTLV_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(2 * N);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    // Both banks share one array: bank b occupies entries [b*N, b*N+N-1].
    logic [DATA_W-1:0] r_mem [0:2*N-1];

    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [RW-1:0] r_wr_row;
    logic [CW-1:0] r_wr_col;
    logic [RW-1:0] r_rd_row;
    logic [CW-1:0] r_rd_col;
    logic [1:0]    r_full;

    logic          w_wr_fire;
    logic          w_rd_fire;
    logic          w_wr_last;
    logic          w_rd_last;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;
    logic [1:0]    w_full_nxt;

    assign s_ready   = !r_full[r_wr_bank];
    assign m_valid   = r_full[r_rd_bank];
    assign w_wr_fire = s_valid && s_ready;
    assign w_rd_fire = m_valid && m_ready;
    assign w_wr_last = w_wr_fire && (r_wr_row == ROW_LAST) && (r_wr_col == COL_LAST);
    assign w_rd_last = w_rd_fire && (r_rd_row == ROW_LAST) && (r_rd_col == COL_LAST);

    // Row-major cell index for both sides; the reader walks it column-major via its counters.
    assign w_wr_addr = AW'(int'(r_wr_bank) * N + int'(r_wr_row) * COLS + int'(r_wr_col));
    assign w_rd_addr = AW'(int'(r_rd_bank) * N + int'(r_rd_row) * COLS + int'(r_rd_col));

    // Output data is zero whenever nothing is offered; the bank being read cannot be written, so it holds under stall.
    assign m_data = m_valid ? r_mem[w_rd_addr] : '0;
    assign m_sof  = m_valid && (r_rd_row == '0) && (r_rd_col == '0);

    // Full-flag update: writer marks its bank full on the last cell, reader frees its bank on the last cell.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_last) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    // Symbol storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_wr_addr] <= s_data;
        end
    end

    // Write pointer: column counter inner, row counter outer, bank toggles after the last cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_bank <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
        end else if (w_wr_fire) begin
            if (r_wr_col == COL_LAST) begin
                r_wr_col <= '0;
                if (r_wr_row == ROW_LAST) begin
                    r_wr_row  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_row <= r_wr_row + RW'(1);
                end
            end else begin
                r_wr_col <= r_wr_col + CW'(1);
            end
        end
    end

    // Read pointer: row counter inner, column counter outer, bank toggles after the last cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_bank <= 1'b0;
            r_rd_row  <= '0;
            r_rd_col  <= '0;
        end else if (w_rd_fire) begin
            if (r_rd_row == ROW_LAST) begin
                r_rd_row <= '0;
                if (r_rd_col == COL_LAST) begin
                    r_rd_col  <= '0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_col <= r_rd_col + CW'(1);
                end
            end else begin
                r_rd_row <= r_rd_row + RW'(1);
            end
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full <= w_full_nxt;
        end
    end

`ifdef INTLV_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Completed output block counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 16'h0000;
        end else if (w_rd_last) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
